repl_sequencer: RTL and testbench

Top-level control FSM for the UART REPL path. It takes each complete 32-bit instruction from the UART instruction receiver and hands it to the core with a valid/ready handshake. It then waits for the core to retire the instruction and returns the destination register index and value to the host as a 5-byte frame, one byte at a time, through the UART transmitter. Only one instruction is in flight at a time. A watchdog turns a hung core into an error frame so the host never stalls.

---
 rtl/repl_sequencer.sv | 127 ++++++++++++
 tb/tb_repl_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/repl_sequencer.sv
// rtl/repl_sequencer.sv - UART REPL control FSM: issue one instruction, await retire, return a 5-byte result frame.
// A saturating watchdog in EXEC converts a hung core into an error frame.
module repl_sequencer #(
  parameter int         TIMEOUT_CYCLES = 1_200_000,
  parameter logic [7:0] ERR_CODE       = 8'hFF
) (
  input  logic        clk12,
  input  logic        rstn,
  input  logic [31:0] instruction,
  input  logic        instruction_rcv,
  output logic [31:0] core_instr,
  output logic        core_instr_valid,
  input  logic        core_instr_ready,
  input  logic        core_done,
  input  logic [4:0]  core_rd,
  input  logic [31:0] core_rd_value,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_ready,
  output logic        busy,
  output logic        dropped
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, EXEC, SEND, GAP, WAIT_TX} state_t;

  state_t          state, state_n;
  logic [31:0]     instr_q, instr_n;
  logic [39:0]     frame_q, frame_n;
  logic [2:0]      cnt_q, cnt_n;
  logic [WD_W-1:0] wd_q, wd_n;
  logic [7:0]      txd_q, txd_n;
  logic            txs_q, txs_n;
  logic            drop_q, drop_n;

  always_ff @(posedge clk12) begin
    if (!rstn) begin
      state   <= IDLE;
      instr_q <= '0;
      frame_q <= '0;
      cnt_q   <= '0;
      wd_q    <= '0;
      txd_q   <= '0;
      txs_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state   <= state_n;
      instr_q <= instr_n;
      frame_q <= frame_n;
      cnt_q   <= cnt_n;
      wd_q    <= wd_n;
      txd_q   <= txd_n;
      txs_q   <= txs_n;
      drop_q  <= drop_n;
    end
  end

  always_comb begin
    state_n = state;
    instr_n = instr_q;
    frame_n = frame_q;
    cnt_n   = cnt_q;
    wd_n    = wd_q;
    txd_n   = txd_q;
    txs_n   = 1'b0;
    drop_n  = instruction_rcv && (state != IDLE);
    case (state)
      IDLE: begin
        if (instruction_rcv) begin
          instr_n = instruction;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (core_instr_ready) begin
          wd_n    = '0;
          state_n = EXEC;
        end
      end
      EXEC: begin
        wd_n = (wd_q == '1) ? wd_q : wd_q + 1'b1;
        // Retirement takes priority over a watchdog expiring in the same cycle
        if (core_done) begin
          frame_n = {core_rd_value, 3'b000, core_rd};
          cnt_n   = '0;
          state_n = SEND;
        end else if (wd_q == WD_LAST) begin
          frame_n = {32'd0, ERR_CODE};
          cnt_n   = '0;
          state_n = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          txd_n   = frame_q[{cnt_q, 3'b000} +: 8];
          txs_n   = 1'b1;
          state_n = GAP;
        end
      end
      GAP: begin
        // Skip sampling tx_ready while the transmitter's busy flag catches up
        state_n = WAIT_TX;
      end
      WAIT_TX: begin
        if (tx_ready) begin
          if (cnt_q == 3'd4) begin
            state_n = IDLE;
          end else begin
            cnt_n   = cnt_q + 3'd1;
            state_n = SEND;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign core_instr       = instr_q;
  assign core_instr_valid = (state == ISSUE);
  assign tx_data          = txd_q;
  assign tx_start         = txs_q;
  assign busy             = (state != IDLE);
  assign dropped          = drop_q;

endmodule

// File: tb/tb_repl_sequencer.sv
// tb/tb_repl_sequencer.sv - self-checking bench for repl_sequencer with a transmitter model and frame scoreboard.
module tb_repl_sequencer;

  localparam int         T   = 16;
  localparam logic [7:0] ERR = 8'hFF;

  logic        clk12 = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] instruction = '0;
  logic        instruction_rcv = 1'b0;
  logic [31:0] core_instr;
  logic        core_instr_valid;
  logic        core_instr_ready = 1'b0;
  logic        core_done = 1'b0;
  logic [4:0]  core_rd = '0;
  logic [31:0] core_rd_value = '0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_ready;
  logic        busy;
  logic        dropped;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] tx_bytes[$];
  int         drop_cnt = 0;
  int         tx_delay = 1;
  int         tx_left = 0;

  repl_sequencer #(.TIMEOUT_CYCLES(T), .ERR_CODE(ERR)) dut (
    .clk12(clk12), .rstn(rstn),
    .instruction(instruction), .instruction_rcv(instruction_rcv),
    .core_instr(core_instr), .core_instr_valid(core_instr_valid), .core_instr_ready(core_instr_ready),
    .core_done(core_done), .core_rd(core_rd), .core_rd_value(core_rd_value),
    .tx_data(tx_data), .tx_start(tx_start), .tx_ready(tx_ready),
    .busy(busy), .dropped(dropped)
  );

  always #5 clk12 = ~clk12;

  // Transmitter: captures each started byte and stays busy for tx_delay cycles
  initial begin : tx_model
    tx_ready = 1'b1;
    forever begin
      @(posedge clk12);
      #1;
      if (dropped === 1'b1) drop_cnt++;
      if (tx_start === 1'b1) begin
        tx_bytes.push_back(tx_data);
        tx_ready = 1'b0;
        tx_left  = tx_delay;
      end else if (tx_left > 0) begin
        tx_left--;
        if (tx_left == 0) tx_ready = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL global_timeout: observed still running expected finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_instr(input logic [31:0] ins, input int ready_dly, input int done_dly,
                           input bit hang, input logic [4:0] rd, input logic [31:0] val,
                           input int drop_at);
    logic [7:0] exp_q[$];
    int  base, drops0, c, lat_exp;
    bit  stable, err;
    err = hang || (done_dly > T - 1);
    exp_q.delete();
    if (err) begin
      exp_q.push_back(ERR);
      for (int i = 0; i < 4; i++) exp_q.push_back(8'h00);
    end else begin
      exp_q.push_back({3'b000, rd});
      for (int i = 0; i < 4; i++) exp_q.push_back(8'((val >> (8 * i)) & 32'hFF));
    end
    base   = tx_bytes.size();
    drops0 = drop_cnt;

    instruction     = ins;
    instruction_rcv = 1'b1;
    @(negedge clk12);
    instruction_rcv = 1'b0;
    instruction     = $urandom;
    chk("issue_valid", core_instr_valid, 1);
    chk("issue_busy", busy, 1);
    chk("issue_instr", core_instr, ins);

    stable = 1'b1;
    repeat (ready_dly) begin
      @(negedge clk12);
      if (core_instr_valid !== 1'b1 || core_instr !== ins) stable = 1'b0;
    end
    chk("hold_stable", stable, 1);

    core_instr_ready = 1'b1;
    @(negedge clk12);
    core_instr_ready = 1'b0;
    chk("exec_valid_low", core_instr_valid, 0);

    c = 0;
    while (tx_start !== 1'b1 && c < 200) begin
      core_done       = (!hang && c == done_dly);
      core_rd         = rd;
      core_rd_value   = val;
      instruction_rcv = (c == drop_at);
      @(negedge clk12);
      c++;
    end
    core_done       = 1'b0;
    instruction_rcv = 1'b0;
    lat_exp = err ? T + 1 : done_dly + 2;
    chk("first_start_latency", c, lat_exp);
    chk("first_tx_data", tx_data, exp_q[0]);

    c = 0;
    while (busy !== 1'b0 && c < 2000) begin
      @(negedge clk12);
      c++;
    end
    chk("frame_done_busy", busy, 0);
    repeat (3) @(negedge clk12);
    chk("start_count", tx_bytes.size() - base, 5);
    for (int i = 0; i < 5; i++)
      if (base + i < tx_bytes.size()) chk($sformatf("frame_byte%0d", i), tx_bytes[base + i], exp_q[i]);
    chk("drop_count", drop_cnt - drops0, (drop_at >= 0) ? 1 : 0);
  endtask

  initial begin : main
    int base, c;
    rstn = 1'b0;
    repeat (3) @(negedge clk12);
    chk("rst_valid", core_instr_valid, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dropped", dropped, 0);
    chk("rst_core_instr", core_instr, 0);
    chk("rst_tx_data", tx_data, 0);
    rstn = 1'b1;
    @(negedge clk12);

    // Normal round trip, back-pressure, timeout
    run_instr(32'h00A00093, 0, 3, 1'b0, 5'd1, 32'h0000000A, -1);
    run_instr(32'h12345678, 10, 2, 1'b0, 5'd7, 32'hDEADBEEF, -1);
    run_instr(32'h0BADF00D, 1, 0, 1'b1, 5'd0, 32'h0, -1);
    // Done on the timeout cycle, done just after it, drop during EXEC
    run_instr(32'h00000013, 0, T - 1, 1'b0, 5'd31, 32'hA5A55A5A, -1);
    run_instr(32'h00000033, 0, T, 1'b0, 5'd3, 32'h11223344, -1);
    run_instr(32'hCAFEBABE, 2, 5, 1'b0, 5'd12, 32'h87654321, 1);

    // Slow transmitter
    tx_delay = 100;
    run_instr(32'h00500113, 0, 1, 1'b0, 5'd2, 32'h00000005, -1);

    for (int k = 0; k < 8; k++) begin
      tx_delay = $urandom_range(8, 1);
      run_instr($urandom, $urandom_range(5, 0), $urandom_range(20, 0), ($urandom_range(7, 0) == 0),
                5'($urandom), $urandom, ($urandom_range(1, 0) == 1) ? 1 : -1);
    end

    // Reset after the third byte has started
    tx_delay = 20;
    base = tx_bytes.size();
    instruction = 32'h00100093;
    instruction_rcv = 1'b1;
    @(negedge clk12);
    instruction_rcv = 1'b0;
    core_instr_ready = 1'b1;
    @(negedge clk12);
    core_instr_ready = 1'b0;
    core_rd = 5'd1;
    core_rd_value = 32'h01020304;
    core_done = 1'b1;
    @(negedge clk12);
    core_done = 1'b0;
    c = 0;
    while (tx_bytes.size() < base + 3 && c < 500) begin
      @(negedge clk12);
      c++;
    end
    chk("reset_pre_starts", tx_bytes.size() - base, 3);
    rstn = 1'b0;
    @(negedge clk12);
    chk("midrst_valid", core_instr_valid, 0);
    chk("midrst_tx_start", tx_start, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_dropped", dropped, 0);
    chk("midrst_core_instr", core_instr, 0);
    chk("midrst_tx_data", tx_data, 0);
    rstn = 1'b1;
    base = tx_bytes.size();
    repeat (300) @(negedge clk12);
    chk("midrst_no_more_starts", tx_bytes.size() - base, 0);
    chk("midrst_idle", busy, 0);
    tx_delay = 3;
    run_instr(32'h00C00213, 1, 4, 1'b0, 5'd4, 32'h0000000C, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
